// File: rtl/force_output_node_router.sv
// force_output_node_router
//   Return path of the inter-node force ring. Partial forces computed by the
//   local PEs are buffered in a small FIFO and injected into the ring. Transit
//   packets are forwarded with their hop lifetime decremented. Packets whose
//   destination is this node's home cell are ejected into the force cache.
//
// Ports
//   clk, rst                       clock, synchronous active-low reset
//   i_ring_*                       upstream ring packet (valid, force, pid, gcid, node id, lifetime)
//   i_pe_*, o_pe_ready             PE force result push handshake into the injection FIFO
//   i_local_gcid, i_local_node_id  identity of this node's home cell
//   i_cache_ready                  force cache can accept a write this cycle
//   o_ring_*                       downstream ring packet (registered)
//   o_cache_valid/_force/_pid      force cache write (registered)
//   o_drop_err, o_recirc           single-cycle event pulses
//   i_flush_req, o_flush_done      drain handshake
//   o_fifo_count                   injection FIFO occupancy
module force_output_node_router #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int GCID_WIDTH        = 15,
  parameter int NODE_ID_WIDTH     = 4,
  parameter int LIFETIME_WIDTH    = 5,
  parameter int MAX_LIFETIME      = 26,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_ring_valid,
  input  logic [3*DATA_WIDTH-1:0]        i_ring_force,
  input  logic [PARTICLE_ID_WIDTH-1:0]   i_ring_pid,
  input  logic [GCID_WIDTH-1:0]          i_ring_gcid,
  input  logic [NODE_ID_WIDTH-1:0]       i_ring_node_id,
  input  logic [LIFETIME_WIDTH-1:0]      i_ring_lifetime,
  input  logic                           i_pe_valid,
  input  logic [3*DATA_WIDTH-1:0]        i_pe_force,
  input  logic [PARTICLE_ID_WIDTH-1:0]   i_pe_pid,
  input  logic [GCID_WIDTH-1:0]          i_pe_gcid,
  input  logic [NODE_ID_WIDTH-1:0]       i_pe_node_id,
  output logic                           o_pe_ready,
  input  logic [GCID_WIDTH-1:0]          i_local_gcid,
  input  logic [NODE_ID_WIDTH-1:0]       i_local_node_id,
  input  logic                           i_cache_ready,
  output logic                           o_ring_valid,
  output logic [3*DATA_WIDTH-1:0]        o_ring_force,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_ring_pid,
  output logic [GCID_WIDTH-1:0]          o_ring_gcid,
  output logic [NODE_ID_WIDTH-1:0]       o_ring_node_id,
  output logic [LIFETIME_WIDTH-1:0]      o_ring_lifetime,
  output logic                           o_cache_valid,
  output logic [3*DATA_WIDTH-1:0]        o_cache_force,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_cache_pid,
  output logic                           o_drop_err,
  output logic                           o_recirc,
  input  logic                           i_flush_req,
  output logic                           o_flush_done,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

  localparam int FW = 3 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = FW + PARTICLE_ID_WIDTH + GCID_WIDTH + NODE_ID_WIDTH;
  localparam logic [LIFETIME_WIDTH-1:0] LT_MAX = LIFETIME_WIDTH'(MAX_LIFETIME);
  localparam logic [LIFETIME_WIDTH-1:0] LT_ONE = LIFETIME_WIDTH'(1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                         state_q, state_d;
  logic                           ring_valid_q, ring_valid_d;
  logic [FW-1:0]                  ring_force_q, ring_force_d;
  logic [PARTICLE_ID_WIDTH-1:0]   ring_pid_q, ring_pid_d;
  logic [GCID_WIDTH-1:0]          ring_gcid_q, ring_gcid_d;
  logic [NODE_ID_WIDTH-1:0]       ring_node_id_q, ring_node_id_d;
  logic [LIFETIME_WIDTH-1:0]      ring_lifetime_q, ring_lifetime_d;
  logic                           cache_valid_q, cache_valid_d;
  logic [FW-1:0]                  cache_force_q, cache_force_d;
  logic [PARTICLE_ID_WIDTH-1:0]   cache_pid_q, cache_pid_d;
  logic                           drop_err_q, drop_err_d;
  logic                           recirc_q, recirc_d;
  logic                           pe_ready_q, pe_ready_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]                  mem_q [FIFO_DEPTH];
  logic [EW-1:0]                  mem_d [FIFO_DEPTH];

  logic                           push, pop;
  logic                           slot_free, cache_used;
  logic                           ring_match, head_match, fifo_empty;
  logic [FW-1:0]                  head_force;
  logic [PARTICLE_ID_WIDTH-1:0]   head_pid;
  logic [GCID_WIDTH-1:0]          head_gcid;
  logic [NODE_ID_WIDTH-1:0]       head_node_id;

  assign fifo_empty = (count_q == '0);
  assign {head_force, head_pid, head_gcid, head_node_id} = mem_q[rd_ptr_q];
  assign ring_match = (i_ring_gcid == i_local_gcid) && (i_ring_node_id == i_local_node_id);
  assign head_match = (head_gcid == i_local_gcid) && (head_node_id == i_local_node_id);

  // pe_ready is registered so it reads 0 while in reset; its value equals
  // (count < depth) & RUN evaluated on the registered state.
  assign push = i_pe_valid && pe_ready_q;

  // Ring/cache arbitration: the incoming ring packet is served first, then the
  // FIFO head takes whatever ring slot or cache port is still free.
  always_comb begin
    ring_valid_d    = 1'b0;
    ring_force_d    = ring_force_q;
    ring_pid_d      = ring_pid_q;
    ring_gcid_d     = ring_gcid_q;
    ring_node_id_d  = ring_node_id_q;
    ring_lifetime_d = ring_lifetime_q;
    cache_valid_d   = 1'b0;
    cache_force_d   = cache_force_q;
    cache_pid_d     = cache_pid_q;
    drop_err_d      = 1'b0;
    recirc_d        = 1'b0;
    pop             = 1'b0;
    slot_free       = 1'b1;
    cache_used      = 1'b0;

    if (i_ring_valid) begin
      if (ring_match) begin
        if (i_cache_ready) begin
          cache_valid_d = 1'b1;
          cache_force_d = i_ring_force;
          cache_pid_d   = i_ring_pid;
          cache_used    = 1'b1;
        end else begin
          // Cache busy: send it round the ring again with a fresh lifetime.
          ring_valid_d    = 1'b1;
          ring_force_d    = i_ring_force;
          ring_pid_d      = i_ring_pid;
          ring_gcid_d     = i_ring_gcid;
          ring_node_id_d  = i_ring_node_id;
          ring_lifetime_d = LT_MAX;
          recirc_d        = 1'b1;
          slot_free       = 1'b0;
        end
      end else if (i_ring_lifetime != '0) begin
        ring_valid_d    = 1'b1;
        ring_force_d    = i_ring_force;
        ring_pid_d      = i_ring_pid;
        ring_gcid_d     = i_ring_gcid;
        ring_node_id_d  = i_ring_node_id;
        ring_lifetime_d = i_ring_lifetime - LT_ONE;
        slot_free       = 1'b0;
      end else begin
        drop_err_d = 1'b1;
      end
    end

    // A locally destined head waits for the cache port and never enters the ring.
    if (!fifo_empty) begin
      if (head_match) begin
        if (!cache_used && i_cache_ready) begin
          pop           = 1'b1;
          cache_valid_d = 1'b1;
          cache_force_d = head_force;
          cache_pid_d   = head_pid;
        end
      end else if (slot_free) begin
        pop             = 1'b1;
        ring_valid_d    = 1'b1;
        ring_force_d    = head_force;
        ring_pid_d      = head_pid;
        ring_gcid_d     = head_gcid;
        ring_node_id_d  = head_node_id;
        ring_lifetime_d = LT_MAX;
      end
    end
  end

  // FIFO bookkeeping and flush state machine.
  always_comb begin
    mem_d = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    if (push) begin
      mem_d[wr_ptr_q] = {i_pe_force, i_pe_pid, i_pe_gcid, i_pe_node_id};
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    case (state_q)
      ST_RUN:   if (i_flush_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_flush_req) state_d = ST_RUN;
        else if (fifo_empty && !ring_valid_q && !i_ring_valid) state_d = ST_DONE;
      end
      ST_DONE:  if (!i_flush_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    pe_ready_d = (count_d < CW'(FIFO_DEPTH)) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_RUN;
      ring_valid_q    <= 1'b0;
      ring_force_q    <= '0;
      ring_pid_q      <= '0;
      ring_gcid_q     <= '0;
      ring_node_id_q  <= '0;
      ring_lifetime_q <= '0;
      cache_valid_q   <= 1'b0;
      cache_force_q   <= '0;
      cache_pid_q     <= '0;
      drop_err_q      <= 1'b0;
      recirc_q        <= 1'b0;
      pe_ready_q      <= 1'b0;
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      state_q         <= state_d;
      ring_valid_q    <= ring_valid_d;
      ring_force_q    <= ring_force_d;
      ring_pid_q      <= ring_pid_d;
      ring_gcid_q     <= ring_gcid_d;
      ring_node_id_q  <= ring_node_id_d;
      ring_lifetime_q <= ring_lifetime_d;
      cache_valid_q   <= cache_valid_d;
      cache_force_q   <= cache_force_d;
      cache_pid_q     <= cache_pid_d;
      drop_err_q      <= drop_err_d;
      recirc_q        <= recirc_d;
      pe_ready_q      <= pe_ready_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign o_pe_ready      = pe_ready_q;
  assign o_ring_valid    = ring_valid_q;
  assign o_ring_force    = ring_force_q;
  assign o_ring_pid      = ring_pid_q;
  assign o_ring_gcid     = ring_gcid_q;
  assign o_ring_node_id  = ring_node_id_q;
  assign o_ring_lifetime = ring_lifetime_q;
  assign o_cache_valid   = cache_valid_q;
  assign o_cache_force   = cache_force_q;
  assign o_cache_pid     = cache_pid_q;
  assign o_drop_err      = drop_err_q;
  assign o_recirc        = recirc_q;
  assign o_flush_done    = (state_q == ST_DONE);
  assign o_fifo_count    = count_q;

endmodule

// File: tb/tb_force_output_node_router.sv
module tb_force_output_node_router;

   localparam logic [14:0] LOCAL_G = 15'h1234;
   localparam logic [3:0]  LOCAL_N = 4'h5;
   localparam logic [14:0] FAR_G   = 15'h0111;
   localparam logic [3:0]  FAR_N   = 4'h2;

   typedef struct {
      int          cyc;
      logic [95:0] frc;
      logic [6:0]  pid;
      logic [14:0] gcid;
      logic [3:0]  node;
      logic [4:0]  lt;
   } ring_exp_t;

   typedef struct {
      int          cyc;
      logic [95:0] frc;
      logic [6:0]  pid;
   } cache_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_ring_valid;
   logic [95:0] i_ring_force;
   logic [6:0]  i_ring_pid;
   logic [14:0] i_ring_gcid;
   logic [3:0]  i_ring_node_id;
   logic [4:0]  i_ring_lifetime;
   logic        i_pe_valid;
   logic [95:0] i_pe_force;
   logic [6:0]  i_pe_pid;
   logic [14:0] i_pe_gcid;
   logic [3:0]  i_pe_node_id;
   logic        o_pe_ready;
   logic [14:0] i_local_gcid;
   logic [3:0]  i_local_node_id;
   logic        i_cache_ready;
   logic        o_ring_valid;
   logic [95:0] o_ring_force;
   logic [6:0]  o_ring_pid;
   logic [14:0] o_ring_gcid;
   logic [3:0]  o_ring_node_id;
   logic [4:0]  o_ring_lifetime;
   logic        o_cache_valid;
   logic [95:0] o_cache_force;
   logic [6:0]  o_cache_pid;
   logic        o_drop_err;
   logic        o_recirc;
   logic        i_flush_req;
   logic        o_flush_done;
   logic [3:0]  o_fifo_count;

   int checkCount = 0;
   int errorCount = 0;
   int cyc = 0;
   ring_exp_t  ringQ[$];
   cache_exp_t cacheQ[$];

   force_output_node_router dut (
      .clk(clk), .rst(rst),
      .i_ring_valid(i_ring_valid), .i_ring_force(i_ring_force), .i_ring_pid(i_ring_pid),
      .i_ring_gcid(i_ring_gcid), .i_ring_node_id(i_ring_node_id), .i_ring_lifetime(i_ring_lifetime),
      .i_pe_valid(i_pe_valid), .i_pe_force(i_pe_force), .i_pe_pid(i_pe_pid),
      .i_pe_gcid(i_pe_gcid), .i_pe_node_id(i_pe_node_id), .o_pe_ready(o_pe_ready),
      .i_local_gcid(i_local_gcid), .i_local_node_id(i_local_node_id), .i_cache_ready(i_cache_ready),
      .o_ring_valid(o_ring_valid), .o_ring_force(o_ring_force), .o_ring_pid(o_ring_pid),
      .o_ring_gcid(o_ring_gcid), .o_ring_node_id(o_ring_node_id), .o_ring_lifetime(o_ring_lifetime),
      .o_cache_valid(o_cache_valid), .o_cache_force(o_cache_force), .o_cache_pid(o_cache_pid),
      .o_drop_err(o_drop_err), .o_recirc(o_recirc),
      .i_flush_req(i_flush_req), .o_flush_done(o_flush_done), .o_fifo_count(o_fifo_count)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   function automatic logic [95:0] mkForce(input int z, input int y, input int x);
      return {z[31:0], y[31:0], x[31:0]};
   endfunction

   // One comparison: counts it and reports a failure with observed/expected
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic driveRing(input logic v, input logic [95:0] f, input logic [6:0] p,
                            input logic [14:0] g, input logic [3:0] n, input logic [4:0] lt);
      i_ring_valid = v; i_ring_force = f; i_ring_pid = p;
      i_ring_gcid = g; i_ring_node_id = n; i_ring_lifetime = lt;
   endtask

   task automatic drivePe(input logic v, input logic [95:0] f, input logic [6:0] p,
                          input logic [14:0] g, input logic [3:0] n);
      i_pe_valid = v; i_pe_force = f; i_pe_pid = p; i_pe_gcid = g; i_pe_node_id = n;
   endtask

   // Expected ring packet, due 'dly' cycles after the next clock edge minus one
   task automatic expectRing(input int dly, input logic [95:0] f, input logic [6:0] p,
                             input logic [14:0] g, input logic [3:0] n, input logic [4:0] lt);
      ring_exp_t e;
      e.cyc = cyc + dly; e.frc = f; e.pid = p; e.gcid = g; e.node = n; e.lt = lt;
      ringQ.push_back(e);
   endtask

   task automatic expectCache(input int dly, input logic [95:0] f, input logic [6:0] p);
      cache_exp_t e;
      e.cyc = cyc + dly; e.frc = f; e.pid = p;
      cacheQ.push_back(e);
   endtask

   // Advance one clock, then score any ring/cache output against the queues
   task automatic applyStimulus();
      ring_exp_t  r;
      cache_exp_t c;
      @(posedge clk);
      #1;
      cyc++;
      if (o_ring_valid) begin
         if (ringQ.size() == 0) checkOutput("ring_unexpected", 1, 0);
         else begin
            r = ringQ.pop_front();
            checkOutput("ring_cycle", cyc, r.cyc);
            checkOutput("ring_force", o_ring_force, r.frc);
            checkOutput("ring_pid", o_ring_pid, r.pid);
            checkOutput("ring_gcid", o_ring_gcid, r.gcid);
            checkOutput("ring_node", o_ring_node_id, r.node);
            checkOutput("ring_lifetime", o_ring_lifetime, r.lt);
         end
      end else if (ringQ.size() > 0 && ringQ[0].cyc <= cyc) begin
         checkOutput("ring_missing", 0, 1);
         void'(ringQ.pop_front());
      end
      if (o_cache_valid) begin
         if (cacheQ.size() == 0) checkOutput("cache_unexpected", 1, 0);
         else begin
            c = cacheQ.pop_front();
            checkOutput("cache_cycle", cyc, c.cyc);
            checkOutput("cache_force", o_cache_force, c.frc);
            checkOutput("cache_pid", o_cache_pid, c.pid);
         end
      end else if (cacheQ.size() > 0 && cacheQ[0].cyc <= cyc) begin
         checkOutput("cache_missing", 0, 1);
         void'(cacheQ.pop_front());
      end
   endtask

   // Directed sequence
   initial begin
      int waited;
      rst = 1'b0;
      i_local_gcid = LOCAL_G;
      i_local_node_id = LOCAL_N;
      i_cache_ready = 1'b1;
      i_flush_req = 1'b0;
      driveRing(1'b0, '0, '0, '0, '0, '0);
      drivePe(1'b1, mkForce(7, 7, 7), 7'd1, FAR_G, FAR_N);

      // Reset held two cycles with a PE push pending
      repeat (2) begin
         applyStimulus();
         checkOutput("rst_ring_valid", o_ring_valid, 0);
         checkOutput("rst_cache_valid", o_cache_valid, 0);
         checkOutput("rst_drop", o_drop_err, 0);
         checkOutput("rst_recirc", o_recirc, 0);
         checkOutput("rst_count", o_fifo_count, 0);
         checkOutput("rst_pe_ready", o_pe_ready, 0);
         checkOutput("rst_done", o_flush_done, 0);
      end
      rst = 1'b1;
      drivePe(1'b0, '0, '0, '0, '0);
      applyStimulus();
      checkOutput("post_rst_pe_ready", o_pe_ready, 1);
      checkOutput("post_rst_count", o_fifo_count, 0);

      // Transit: forwarded with lifetime-1, then lifetime 0 dropped
      driveRing(1'b1, mkForce(30, 20, 10), 7'd5, FAR_G, FAR_N, 5'd5);
      expectRing(1, mkForce(30, 20, 10), 7'd5, FAR_G, FAR_N, 5'd4);
      applyStimulus();
      checkOutput("transit_drop", o_drop_err, 0);
      driveRing(1'b1, mkForce(31, 21, 11), 7'd6, FAR_G, FAR_N, 5'd0);
      applyStimulus();
      checkOutput("drop_pulse", o_drop_err, 1);
      checkOutput("drop_ring_valid", o_ring_valid, 0);
      driveRing(1'b0, '0, '0, '0, '0, '0);
      applyStimulus();
      checkOutput("drop_one_cycle", o_drop_err, 0);

      // Eject when cache ready, recirculate when busy
      driveRing(1'b1, mkForce(3, 2, 1), 7'd9, LOCAL_G, LOCAL_N, 5'd3);
      expectCache(1, mkForce(3, 2, 1), 7'd9);
      applyStimulus();
      checkOutput("eject_recirc", o_recirc, 0);
      i_cache_ready = 1'b0;
      expectRing(1, mkForce(3, 2, 1), 7'd9, LOCAL_G, LOCAL_N, 5'd26);
      applyStimulus();
      checkOutput("recirc_pulse", o_recirc, 1);
      checkOutput("recirc_cache_valid", o_cache_valid, 0);
      i_cache_ready = 1'b1;

      // Fill the FIFO under continuous transit traffic, then two refused pushes
      for (int k = 0; k < 10; k++) begin
         drivePe(1'b1, mkForce(k + 20, k + 10, k), 7'(k), 15'h0200 + 15'(k), 4'h3);
         driveRing(1'b1, mkForce(100 + k, 0, 1), 7'(40 + k), FAR_G, FAR_N, 5'd10);
         expectRing(1, mkForce(100 + k, 0, 1), 7'(40 + k), FAR_G, FAR_N, 5'd9);
         applyStimulus();
      end
      checkOutput("full_count", o_fifo_count, 8);
      checkOutput("full_pe_ready", o_pe_ready, 0);

      // Ring idles: eight injections in FIFO order on consecutive cycles
      drivePe(1'b0, '0, '0, '0, '0);
      driveRing(1'b0, '0, '0, '0, '0, '0);
      for (int k = 0; k < 8; k++)
         expectRing(1 + k, mkForce(k + 20, k + 10, k), 7'(k), 15'h0200 + 15'(k), 4'h3, 5'd26);
      repeat (8) applyStimulus();
      checkOutput("drained_count", o_fifo_count, 0);
      checkOutput("drained_pe_ready", o_pe_ready, 1);

      // Local head competes with a matching ring packet for the cache
      i_cache_ready = 1'b0;
      drivePe(1'b1, mkForce(66, 55, 44), 7'd33, LOCAL_G, LOCAL_N);
      applyStimulus();
      checkOutput("local_head_count", o_fifo_count, 1);
      drivePe(1'b0, '0, '0, '0, '0);
      i_cache_ready = 1'b1;
      driveRing(1'b1, mkForce(9, 8, 7), 7'd12, LOCAL_G, LOCAL_N, 5'd4);
      expectCache(1, mkForce(9, 8, 7), 7'd12);
      applyStimulus();
      checkOutput("conflict_head_stays", o_fifo_count, 1);
      driveRing(1'b0, '0, '0, '0, '0, '0);
      expectCache(1, mkForce(66, 55, 44), 7'd33);
      applyStimulus();
      checkOutput("head_ejected_count", o_fifo_count, 0);

      // Flush: load three entries behind ring traffic, then drain
      for (int k = 0; k < 3; k++) begin
         drivePe(1'b1, mkForce(0, 5, 50 + k), 7'(60 + k), 15'h0300, 4'h7);
         driveRing(1'b1, mkForce(1, 1, 200 + k), 7'(70 + k), FAR_G, FAR_N, 5'd10);
         expectRing(1, mkForce(1, 1, 200 + k), 7'(70 + k), FAR_G, FAR_N, 5'd9);
         applyStimulus();
      end
      checkOutput("flush_pre_count", o_fifo_count, 3);
      drivePe(1'b0, '0, '0, '0, '0);
      driveRing(1'b0, '0, '0, '0, '0, '0);
      i_flush_req = 1'b1;
      for (int k = 0; k < 3; k++)
         expectRing(1 + k, mkForce(0, 5, 50 + k), 7'(60 + k), 15'h0300, 4'h7, 5'd26);
      applyStimulus();
      checkOutput("flush_pe_ready", o_pe_ready, 0);
      waited = 1;
      while (!o_flush_done && waited < 5) begin
         applyStimulus();
         waited++;
      end
      checkOutput("flush_done", o_flush_done, 1);
      checkOutput("flush_done_pe_ready", o_pe_ready, 0);
      checkOutput("flush_done_count", o_fifo_count, 0);
      i_flush_req = 1'b0;
      applyStimulus();
      checkOutput("run_done_clear", o_flush_done, 0);
      checkOutput("run_pe_ready", o_pe_ready, 1);

      applyStimulus();
      checkOutput("ring_queue_left", ringQ.size(), 0);
      checkOutput("cache_queue_left", cacheQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
